i2s_dac_tx: RTL
===============

# i2s_dac_tx

I2S transmitter for the tone-generator audio path; sits directly downstream of the wave-ROM lookup and drives the external audio DAC. It generates the bit clock and the left/right word clock. The word clock also serves as the channel clock for the ROM address generator. The block latches one left and one right ROM sample per frame and shifts them out MSB-first in standard I2S format.

## Interface
Parameters:
- BCLK_DIV, 4, clk cycles per bclk half-period; legal range ≥1
- SAMPLE_W, 8, width of sample_l/sample_r; legal range 1..16
- OFFSET_BIN, 1, 1 = invert sample MSB before transmit (unsigned ROM data to two's complement); 0 = send as-is

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- sample_l  in  SAMPLE_W  left-channel sample from ROM
- sample_r  in  SAMPLE_W  right-channel sample from ROM
- bclk  out  1  I2S bit clock
- lrck  out  1  I2S word clock (0 = left, 1 = right); also feeds the ROM address generator channel clock
- sdata  out  1  I2S serial data
- frame_start  out  1  one-clk pulse when samples are latched

## Operation
- div_cnt counts 0..BCLK_DIV-1 each clk and wraps. On wrap, bclk toggles.
- Frame bit index b (5 bits, 0..31) advances by 1 (mod 32) on each clk in which bclk toggles 1→0 (the "fall event"). All outputs change only on fall events, except frame_start, which clears 1 clk later.
- On the fall event entering b=0:
  - sample_l and sample_r are latched into shift registers. If OFFSET_BIN=1, the MSB is inverted. Each sample is left-justified in a 16-bit slot and zero-padded.
  - frame_start=1 for exactly that one clk.
- Inputs are ignored at all other times. Changes mid-frame do not affect the current frame.
- lrck is 1 for b in 15..30 and 0 for b = 31 and b in 0..14. lrck therefore changes one bit before each slot's MSB.
- sdata by bit index:
  - b=0..15: left slot bit (15-b)
  - b=16..31: right slot bit (31-b)
  - Bits beyond SAMPLE_W are 0.
- The DAC samples sdata and lrck on bclk rising edges. Both are stable for a full bclk period around each rising edge.
- All outputs are driven from flops, with no combinational paths from inputs to outputs.

## Timing
- Reset (asynchronous, effective immediately while rst_n=0):
  - bclk=0, lrck=0, sdata=0, frame_start=0
  - div_cnt=0, b=31, shift registers=0
- After rst_n rises:
  - bclk rises at the BCLK_DIV-th clk edge.
  - The first fall event occurs at the 2·BCLK_DIV-th edge. It enters b=0, latches samples, pulses frame_start, and drives sdata = left MSB.
- Periods:
  - bclk period = 2·BCLK_DIV clk
  - frame = 32 bclk = 64·BCLK_DIV clk
  - frame_start period = 64·BCLK_DIV clk
  - lrck high time = low time = 32·BCLK_DIV clk
- Upstream requirement:
  - The address generator advances on the lrck edges, at b=15 and b=31.
  - Samples must be stable at the fall event entering b=0. The ROM therefore has at least 2·BCLK_DIV clk of settle time after the lrck falling edge.
- Reset asserted mid-frame: outputs clear immediately and the partial frame is dropped. Restart follows the post-reset sequence above.
- b wraps 31→0 with no idle bits. Transmission is continuous.
- BCLK_DIV=1: bclk toggles every clk. All rules above still hold.

## Test plan
- Reset: hold rst_n low 10 clk.
  - During reset: bclk, lrck, sdata, frame_start all 0.
  - After release (BCLK_DIV=4): bclk rises at clk 4; the first fall and frame_start pulse occur at clk 8; frame_start repeats every 256 clk.
- Data format: OFFSET_BIN=0, sample_l=0xA5, sample_r=0x3C, sampling sdata on bclk rising edges over one frame.
  - Left slot (lrck=0): 1010_0101_0000_0000.
  - Right slot (lrck=1): 0011_1100_0000_0000.
  - lrck transitions occur one bit before each MSB.
- Offset-binary conversion: OFFSET_BIN=1.
  - sample_l=0x80 → left slot 0x0000.
  - sample_r=0x00 → right slot 0x8000.
  - sample_l=0xFF → left slot 0x7F00.
- Mid-frame input change: change sample_l from 0x11 to 0xEE at b=5.
  - Current frame still transmits 0x11.
  - Next frame transmits 0xEE.
- Reset mid-frame: assert rst_n low at b=10 between clk edges.
  - Outputs are 0 before the next clk edge.
  - After release, sequence matches the reset scenario exactly.
- BCLK_DIV=1, SAMPLE_W=16, sample_l=0x8001:
  - bclk toggles every clk.
  - frame_start period is 64 clk.
  - Left slot carries 0x0001 (OFFSET_BIN=1).

Source files
------------

// File: rtl/i2s_dac_tx.sv
// I2S transmitter: divides clk into bclk/lrck, latches one left/right ROM sample per
// 32-bit frame and shifts them out MSB-first in standard I2S framing.
module i2s_dac_tx #(
  parameter int BCLK_DIV   = 4,
  parameter int SAMPLE_W   = 8,
  parameter int OFFSET_BIN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  output logic                bclk,
  output logic                lrck,
  output logic                sdata,
  output logic                frame_start
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [SAMPLE_W-1:0] MSB_MASK =
    (OFFSET_BIN != 0) ? (SAMPLE_W'(1) << (SAMPLE_W - 1)) : '0;

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_idx;
  logic [4:0]       bit_nxt;
  logic             div_wrap;
  logic             fall_evt;
  logic [15:0]      slot_l;
  logic [15:0]      slot_r;
  logic [30:0]      frame_sr;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign fall_evt = div_wrap & bclk;
  assign bit_nxt  = bit_idx + 5'd1;

  // Samples are left-justified in a 16-bit slot; low bits pad with zeros.
  assign slot_l = 16'(sample_l ^ MSB_MASK) << (16 - SAMPLE_W);
  assign slot_r = 16'(sample_r ^ MSB_MASK) << (16 - SAMPLE_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      bclk        <= 1'b0;
      bit_idx     <= 5'd31;
      lrck        <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      frame_sr    <= '0;
    end else begin
      div_cnt     <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      frame_start <= 1'b0;
      if (div_wrap) begin
        bclk <= ~bclk;
      end
      if (fall_evt) begin
        bit_idx <= bit_nxt;
        // lrck leads each slot's MSB by one bit, as I2S requires.
        lrck    <= (bit_nxt >= 5'd15) && (bit_nxt <= 5'd30);
        if (bit_idx == 5'd31) begin
          sdata       <= slot_l[15];
          frame_sr    <= {slot_l[14:0], slot_r};
          frame_start <= 1'b1;
        end else begin
          sdata    <= frame_sr[30];
          frame_sr <= {frame_sr[29:0], 1'b0};
        end
      end
    end
  end

endmodule
